// File: rtl/calc_undo_pkg.sv
// Shared definitions for the undo-capable accumulator calculator.
// Opcode encoding matches the {btnl, btnc, btnr} button order.
package calc_undo_pkg;

  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpAnd = 3'b010,
    OpOr  = 3'b011,
    OpXor = 3'b100,
    OpLt  = 3'b101,
    OpSll = 3'b110,
    OpSra = 3'b111
  } op_e;

endpackage

// File: rtl/calc_undo_if.sv
// Button, switch and status bundle between the board front-end and calc_undo.
interface calc_undo_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
);
  logic                       btnd;
  logic                       btn_undo;
  logic                       btnl;
  logic                       btnc;
  logic                       btnr;
  logic [WIDTH-1:0]           sw;
  logic [WIDTH-1:0]           led;
  logic                       zero;
  logic                       ovf;
  logic [$clog2(DEPTH):0]     hist_cnt;

  modport master (
    output btnd, btn_undo, btnl, btnc, btnr, sw,
    input  led, zero, ovf, hist_cnt
  );

  modport slave (
    input  btnd, btn_undo, btnl, btnc, btnr, sw,
    output led, zero, ovf, hist_cnt
  );
endinterface

// File: rtl/calc_alu.sv
// Combinational ALU for the accumulator calculator.
// ovf flags signed overflow for ADD/SUB only; shifts use the low log2(WIDTH) bits of b.
module calc_alu
  import calc_undo_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] y,
  output logic             ovf
);
  localparam int unsigned ShW = $clog2(WIDTH);

  logic [ShW-1:0]   shamt;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  assign shamt = b[ShW-1:0];
  assign sum   = a + b;
  assign diff  = a - b;

  always_comb begin
    y   = '0;
    ovf = 1'b0;
    unique case (op)
      OpAdd: begin
        y   = sum;
        ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OpSub: begin
        y   = diff;
        ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OpAnd: y = a & b;
      OpOr:  y = a | b;
      OpXor: y = a ^ b;
      OpLt:  y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OpSll: y = a << shamt;
      OpSra: y = $unsigned($signed(a) >>> shamt);
    endcase
  end
endmodule

// File: rtl/calc_undo.sv
// Accumulator calculator with edge-detected buttons and a DEPTH-entry circular undo history.
// The oldest history entry is silently overwritten once the history is full.
module calc_undo
  import calc_undo_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input logic       clk,
  input logic       btnu,
  calc_undo_if.slave io
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic             btnd_q, undo_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [PtrW-1:0]  wptr_q, wptr_d, wptr_dec;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             exec, undo, do_undo;
  logic [WIDTH-1:0] alu_y;
  logic             alu_ovf;
  op_e              op;

  assign op       = op_e'({io.btnl, io.btnc, io.btnr});
  assign exec     = io.btnd & ~btnd_q;
  // Exec wins a same-cycle collision; the undo edge is dropped.
  assign undo     = io.btn_undo & ~undo_q & ~exec;
  assign do_undo  = undo && (cnt_q != '0);
  assign wptr_dec = wptr_q - 1'b1;

  calc_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a   (acc_q),
    .b   (io.sw),
    .op  (op),
    .y   (alu_y),
    .ovf (alu_ovf)
  );

  always_comb begin
    acc_d  = acc_q;
    ovf_d  = ovf_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    if (exec) begin
      acc_d  = alu_y;
      ovf_d  = alu_ovf;
      wptr_d = wptr_q + 1'b1;
      cnt_d  = (cnt_q == CntW'(DEPTH)) ? cnt_q : cnt_q + 1'b1;
    end else if (do_undo) begin
      acc_d  = mem[wptr_dec];
      ovf_d  = 1'b0;
      wptr_d = wptr_dec;
      cnt_d  = cnt_q - 1'b1;
    end
  end

  // Edge-detect copies reset high so a button held through reset does not fire.
  always_ff @(posedge clk or posedge btnu) begin
    if (btnu) begin
      btnd_q <= 1'b1;
      undo_q <= 1'b1;
      acc_q  <= '0;
      ovf_q  <= 1'b0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      btnd_q <= io.btnd;
      undo_q <= io.btn_undo;
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (exec) begin
      mem[wptr_q] <= acc_q;
    end
  end

  assign io.led      = acc_q;
  assign io.zero     = (acc_q == '0);
  assign io.ovf      = ovf_q;
  assign io.hist_cnt = cnt_q;
endmodule

// File: tb/tb_calc_undo.sv
// Self-checking bench for calc_undo (WIDTH=16, DEPTH=4): directed scenarios plus a random
// phase, all compared against an arithmetic model with a bounded history queue.
module tb_calc_undo;
  localparam int unsigned W = 16;
  localparam int unsigned D = 4;

  logic clk;
  logic btnu;
  int   checks;
  int   errors;

  logic [W-1:0] m_acc;
  logic         m_ovf;
  logic [W-1:0] hist[$];

  calc_undo_if #(.WIDTH(W), .DEPTH(D)) io ();

  calc_undo #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk  (clk),
    .btnu (btnu),
    .io   (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".led"},  {16'h0, io.led}, {16'h0, m_acc});
    check({tag, ".zero"}, {31'h0, io.zero}, {31'h0, (m_acc == 16'h0)});
    check({tag, ".ovf"},  {31'h0, io.ovf}, {31'h0, m_ovf});
    check({tag, ".hist"}, {29'h0, io.hist_cnt}, 32'(hist.size()));
  endtask

  function automatic void model_reset();
    m_acc = '0;
    m_ovf = 1'b0;
    hist.delete();
  endfunction

  // Plain integer arithmetic: overflow means the true signed result leaves the 16-bit range.
  function automatic void model_exec(input logic [2:0] op, input logic [W-1:0] b);
    int sa, sb, r;
    int sh;
    sa    = int'($signed(m_acc));
    sb    = int'($signed(b));
    sh    = int'(b[3:0]);
    m_ovf = 1'b0;
    case (op)
      3'd0: begin r = sa + sb; m_ovf = (r > 32767) || (r < -32768); end
      3'd1: begin r = sa - sb; m_ovf = (r > 32767) || (r < -32768); end
      3'd2: r = int'(m_acc & b);
      3'd3: r = int'(m_acc | b);
      3'd4: r = int'(m_acc ^ b);
      3'd5: r = (sa < sb) ? 1 : 0;
      3'd6: r = int'(m_acc) << sh;
      default: r = sa >>> sh;
    endcase
    hist.push_back(m_acc);
    if (hist.size() > D) void'(hist.pop_front());
    m_acc = r[W-1:0];
  endfunction

  function automatic void model_undo();
    if (hist.size() > 0) begin
      m_acc = hist.pop_back();
      m_ovf = 1'b0;
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    btnu = 1'b1;
    model_reset();
    @(negedge clk);
    btnu = 1'b0;
  endtask

  // Press execute, hold it for 'hold' cycles, release; the DUT must act exactly once.
  task automatic press(input logic [2:0] op, input logic [W-1:0] b, input int hold);
    @(negedge clk);
    {io.btnl, io.btnc, io.btnr} = op;
    io.sw   = b;
    io.btnd = 1'b1;
    model_exec(op, b);
    repeat (hold) @(negedge clk);
    io.btnd = 1'b0;
  endtask

  task automatic press_undo();
    @(negedge clk);
    io.btn_undo = 1'b1;
    model_undo();
    @(negedge clk);
    io.btn_undo = 1'b0;
  endtask

  task automatic press_both(input logic [2:0] op, input logic [W-1:0] b);
    @(negedge clk);
    {io.btnl, io.btnc, io.btnr} = op;
    io.sw       = b;
    io.btnd     = 1'b1;
    io.btn_undo = 1'b1;
    model_exec(op, b);
    @(negedge clk);
    io.btnd     = 1'b0;
    io.btn_undo = 1'b0;
  endtask

  initial begin
    logic [W-1:0] led_hist [4];
    checks = 0;
    errors = 0;
    btnu = 1'b1;
    io.btnd = 1'b0; io.btn_undo = 1'b0;
    io.btnl = 1'b0; io.btnc = 1'b0; io.btnr = 1'b0;
    io.sw = '0;
    model_reset();
    repeat (2) @(negedge clk);
    btnu = 1'b0;
    @(negedge clk);
    check_all("reset");

    // Basic logic ops
    press(3'b011, 16'h1234, 1);
    check_all("or");
    check("or_const", {16'h0, io.led}, 32'h1234);
    press(3'b010, 16'h0ff0, 1);
    check("and_const", {16'h0, io.led}, 32'h0230);

    // Overflow, arithmetic shift, signed compare
    do_reset();
    press(3'b011, 16'h0001, 1);
    press(3'b000, 16'h7fff, 1);
    check_all("add_ovf");
    check("add_ovf_flag", {31'h0, io.ovf}, 32'h1);
    press(3'b111, 16'h0004, 1);
    check("sra_const", {16'h0, io.led}, 32'hF800);
    check_all("sra");
    press(3'b101, 16'h0000, 1);
    check("lt_const", {16'h0, io.led}, 32'h0001);

    // History wrap and underflow
    do_reset();
    for (int i = 1; i <= 5; i++) press(3'b000, 16'(i), 1);
    check("hist_full", {29'h0, io.hist_cnt}, 32'd4);
    led_hist[0] = 16'd10; led_hist[1] = 16'd6; led_hist[2] = 16'd3; led_hist[3] = 16'd1;
    for (int i = 0; i < 4; i++) begin
      press_undo();
      check("undo_led", {16'h0, io.led}, {16'h0, led_hist[i]});
    end
    press_undo();
    check("undo_empty_led", {16'h0, io.led}, 32'h0001);
    check_all("undo_empty");

    // Held execute fires once
    do_reset();
    press(3'b000, 16'h0001, 5);
    check("hold_once", {16'h0, io.led}, 32'h0001);
    press(3'b000, 16'h0001, 1);
    check_all("hold_again");

    // Exec beats a simultaneous undo
    do_reset();
    press(3'b011, 16'h0005, 1);
    press_both(3'b000, 16'h0002);
    check("both_led", {16'h0, io.led}, 32'h0007);
    check_all("both");

    // Asynchronous reset mid-press
    do_reset();
    @(negedge clk);
    {io.btnl, io.btnc, io.btnr} = 3'b011;
    io.sw   = 16'h00AA;
    io.btnd = 1'b1;
    @(posedge clk);
    #2;
    check("pre_rst_led", {16'h0, io.led}, 32'h00AA);
    btnu = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    {io.btnl, io.btnc, io.btnr} = 3'b000;
    io.sw = 16'h0001;
    btnu  = 1'b0;
    repeat (3) @(negedge clk);
    check_all("held_thru_rst");
    io.btnd = 1'b0;
    press(3'b000, 16'h0001, 1);
    check_all("after_rst_press");

    // Random mix of exec / undo / collisions / idle
    do_reset();
    for (int n = 0; n < 300; n++) begin
      int unsigned sel;
      sel = $urandom_range(0, 9);
      if (sel < 5) press(3'($urandom_range(0, 7)), 16'($urandom), $urandom_range(1, 3));
      else if (sel < 8) press_undo();
      else if (sel == 8) press_both(3'($urandom_range(0, 7)), 16'($urandom));
      else @(negedge clk);
      check_all("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
